// File: rtl/cnt_rate_sampler.sv
// Windowed rate sampler for a free-running event counter: per-window increment with valid/ready readout.
// Optional peak-hold of the per-window rate is enabled by defining RATE_PEAK_HOLD_EN.
module cnt_rate_sampler #(
  parameter int unsigned CNT_W      = 48,
  parameter int unsigned WIN_CYCLES = 125000000,
  parameter int unsigned WIN_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] rate_data,
  output logic [15:0]      rate_seq,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [15:0]      ovr_cnt,
  output logic [CNT_W-1:0] rate_peak
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [WIN_W-1:0] TICK_AT = WIN_W'(WIN_CYCLES - 1);

  state_t           state;
  logic [WIN_W-1:0] timer;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] delta;
  logic             tick;
  logic             load;
  logic             accept;

  assign tick   = (state == MEASURE) && (timer == TICK_AT);
  // run drop and cnt_clr both discard the window, so neither may produce output on a tick
  assign load   = tick && run && !cnt_clr;
  assign accept = rate_valid && rate_ready;
  assign delta  = cnt_in - last_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      last_cnt   <= '0;
      rate_data  <= '0;
      rate_seq   <= '0;
      rate_valid <= 1'b0;
      ovr_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (run) begin
            state    <= MEASURE;
            last_cnt <= cnt_in;
            rate_seq <= '0;
            ovr_cnt  <= '0;
          end
        end
        MEASURE: begin
          if (!run) begin
            state <= IDLE;
            timer <= '0;
          end else if (cnt_clr) begin
            last_cnt <= '0;
            timer    <= '0;
          end else if (tick) begin
            timer     <= '0;
            last_cnt  <= cnt_in;
            rate_data <= delta;
            rate_seq  <= rate_seq + 16'd1;
            if (rate_valid && !rate_ready && (ovr_cnt != '1))
              ovr_cnt <= ovr_cnt + 16'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load)
        rate_valid <= 1'b1;
      else if (accept)
        rate_valid <= 1'b0;
    end
  end

`ifdef RATE_PEAK_HOLD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rate_peak <= '0;
    else if ((state == IDLE) && run)
      rate_peak <= '0;
    else if (load && (delta > rate_peak))
      rate_peak <= delta;
  end
`else
  assign rate_peak = '0;
`endif

endmodule

// File: tb/tb_cnt_rate_sampler.sv
// Scoreboard bench for cnt_rate_sampler with a 10-cycle window; expected snapshots are queued
// when a window is started and checked against each accepted handshake.
module tb_cnt_rate_sampler;

  localparam int unsigned CW = 48;

`ifdef RATE_PEAK_HOLD_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  typedef struct {
    logic [CW-1:0] d;
    logic [15:0]   s;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [CW-1:0] cnt_in;
  logic          cnt_clr;
  logic [CW-1:0] rate_data;
  logic [15:0]   rate_seq;
  logic          rate_valid;
  logic          rate_ready;
  logic [15:0]   ovr_cnt;
  logic [CW-1:0] rate_peak;

  logic [CW-1:0] step;
  snap_t         sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_push   = 0;
  int            n_acc    = 0;

  cnt_rate_sampler #(.CNT_W(CW), .WIN_CYCLES(10), .WIN_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .cnt_in     (cnt_in),
    .cnt_clr    (cnt_clr),
    .rate_data  (rate_data),
    .rate_seq   (rate_seq),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .ovr_cnt    (ovr_cnt),
    .rate_peak  (rate_peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [CW-1:0] d, input logic [15:0] s);
    snap_t e;
    e.d = d;
    e.s = s;
    sb.push_back(e);
    n_push++;
  endtask

  // Upstream counter model: advances by step on every edge, cnt_clr is a one-cycle pulse.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      cnt_in  = cnt_in + step;
    end
  endtask

  function automatic logic [63:0] pk(input logic [63:0] v);
    return PEAK_ON ? v : 64'd0;
  endfunction

  always @(negedge clk) begin
    if (!rst && rate_valid && rate_ready) begin
      chk("sb_depth", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        snap_t e;
        e = sb.pop_front();
        chk("sb_data", 64'(rate_data), 64'(e.d));
        chk("sb_seq", 64'(rate_seq), 64'(e.s));
        n_acc++;
      end
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; cnt_in = '0; cnt_clr = 1'b0; rate_ready = 1'b0; step = '0;
    cyc(2);
    chk("rst_valid", 64'(rate_valid), 64'd0);
    chk("rst_data", 64'(rate_data), 64'd0);
    chk("rst_seq", 64'(rate_seq), 64'd0);
    chk("rst_ovr", 64'(ovr_cnt), 64'd0);
    chk("rst_peak", 64'(rate_peak), 64'd0);
    rst = 1'b0;
    cyc(2);

    // Basic windows: +1/cycle from 100
    cnt_in = 48'd100; step = 48'd1; rate_ready = 1'b1; run = 1'b1;
    push(48'd10, 16'd1); push(48'd10, 16'd2);
    cyc(10);
    chk("s1_valid_early", 64'(rate_valid), 64'd0);
    cyc(1);
    chk("s1_valid", 64'(rate_valid), 64'd1);
    chk("s1_data", 64'(rate_data), 64'd10);
    chk("s1_seq", 64'(rate_seq), 64'd1);
    cyc(10);
    chk("s1_seq2", 64'(rate_seq), 64'd2);
    run = 1'b0;
    cyc(3);
    chk("s1_idle_valid", 64'(rate_valid), 64'd0);

    // Wrap across 2^48
    cnt_in = 48'hFFFF_FFFF_FFFA; run = 1'b1;
    push(48'd10, 16'd1);
    cyc(11);
    chk("wrap_data", 64'(rate_data), 64'd10);
    run = 1'b0;
    cyc(3);

    // Overrun: reader stalled across three ticks, +2/cycle
    step = 48'd2; rate_ready = 1'b0; run = 1'b1;
    push(48'd20, 16'd3);
    cyc(31);
    chk("ovr_valid", 64'(rate_valid), 64'd1);
    chk("ovr_data", 64'(rate_data), 64'd20);
    chk("ovr_seq", 64'(rate_seq), 64'd3);
    chk("ovr_cnt", 64'(ovr_cnt), 64'd2);
    rate_ready = 1'b1; run = 1'b0;
    cyc(1);
    chk("ovr_accept_valid", 64'(rate_valid), 64'd0);
    chk("ovr_cnt_hold", 64'(ovr_cnt), 64'd2);
    cyc(2);

    // Accept coincident with tick
    step = 48'd1; rate_ready = 1'b0; run = 1'b1;
    push(48'd10, 16'd1); push(48'd10, 16'd2);
    cyc(20);
    rate_ready = 1'b1;
    cyc(1);
    chk("coin_valid", 64'(rate_valid), 64'd1);
    chk("coin_seq", 64'(rate_seq), 64'd2);
    chk("coin_ovr", 64'(ovr_cnt), 64'd0);
    run = 1'b0;
    cyc(3);
    chk("coin_drain", 64'(rate_valid), 64'd0);

    // cnt_clr on the tick cycle; upstream reads 0 in the clear cycle
    cnt_in = 48'd50; run = 1'b1;
    push(48'd10, 16'd1); push(48'd10, 16'd2);
    cyc(20);
    cnt_clr = 1'b1; cnt_in = '0;
    cyc(1);
    chk("clr_valid", 64'(rate_valid), 64'd0);
    chk("clr_seq", 64'(rate_seq), 64'd1);
    cyc(10);
    chk("clr_next_valid", 64'(rate_valid), 64'd1);
    chk("clr_next_data", 64'(rate_data), 64'd10);
    chk("clr_next_seq", 64'(rate_seq), 64'd2);
    run = 1'b0;
    cyc(3);

    // Peak over deltas 5, 12, 7 then async reset with a pending snapshot
    step = '0; cnt_in = '0; run = 1'b1;
    push(48'd5, 16'd1); push(48'd12, 16'd2);
    cyc(10); cnt_in = 48'd5;
    cyc(1);
    chk("peak1", 64'(rate_peak), pk(64'd5));
    cyc(9); cnt_in = 48'd17;
    cyc(1);
    chk("peak2", 64'(rate_peak), pk(64'd12));
    cyc(9); cnt_in = 48'd24; rate_ready = 1'b0;
    cyc(1);
    chk("peak3", 64'(rate_peak), pk(64'd12));
    chk("peak3_data", 64'(rate_data), 64'd7);
    chk("peak3_valid", 64'(rate_valid), 64'd1);
    cyc(3);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(rate_valid), 64'd0);
    chk("arst_data", 64'(rate_data), 64'd0);
    chk("arst_seq", 64'(rate_seq), 64'd0);
    chk("arst_ovr", 64'(ovr_cnt), 64'd0);
    chk("arst_peak", 64'(rate_peak), 64'd0);
    run = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_valid", 64'(rate_valid), 64'd0);

    chk("sb_drain", 64'(sb.size()), 64'd0);
    chk("sb_accepts", 64'(n_acc), 64'(n_push));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_rate_sampler.md
Name: cnt_rate_sampler

Overview:
Downstream consumer of the 48-bit free-running event counter; samples its `cnt` value at fixed window boundaries.
Computes the per-window increment (rate), wrap-safe modulo 2^CNT_W.
Presents each result as a registered snapshot with a valid/ready handshake to the PCIe status/register readout logic.
Tracks window sequence number and overrun events when the reader falls behind.

Parameters:
CNT_W, 48, width of sampled counter and of rate result
WIN_CYCLES, 125000000, window length in clk cycles (1 s at 125 MHz); legal range 2..2^WIN_W-1
WIN_W, 32, width of internal window timer

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = measuring, 0 = idle
cnt_in  in  CNT_W  running count from upstream event counter
cnt_clr  in  1  pulse, asserted in the same cycle the upstream counter is synchronously cleared
rate_data  out  CNT_W  increment of cnt_in over last completed window
rate_seq  out  16  window sequence number of rate_data
rate_valid  out  1  snapshot available
rate_ready  in  1  reader accepts snapshot when rate_valid & rate_ready
ovr_cnt  out  16  count of snapshots overwritten before acceptance, saturating
rate_peak  out  CNT_W  max rate since run rose (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE, timer=0, last_cnt=0, rate_data=0, rate_seq=0, rate_valid=0, ovr_cnt=0, rate_peak=0.
- States:
  - IDLE: timer held at 0.
  - MEASURE.
- IDLE->MEASURE on run=1:
  - last_cnt <= cnt_in in that cycle; timer <= 0.
  - rate_seq <= 0; ovr_cnt <= 0; rate_peak <= 0.
- MEASURE->IDLE on run=0:
  - Timer cleared; partial window discarded.
  - A pending rate_valid stays asserted until accepted.
- Timer in MEASURE:
  - Increments each cycle.
  - tick = (timer == WIN_CYCLES-1); on tick, timer <= 0.
  - Ticks are spaced exactly WIN_CYCLES cycles apart; the first tick is WIN_CYCLES cycles after the entry cycle.
- On tick:
  - delta = cnt_in - last_cnt, truncated to CNT_W bits (wrap-safe).
  - last_cnt <= cnt_in; rate_data <= delta; rate_seq <= rate_seq+1 (wraps at 16 bits); rate_valid <= 1.
  - Latency: rate_valid rises the cycle after tick.
- Handshake:
  - rate_data and rate_seq are stable while rate_valid=1 and no tick occurs.
  - Accept clears rate_valid next cycle unless a tick loads a new snapshot in the same cycle.
- Overrun:
  - tick while rate_valid=1 and rate_ready=0: snapshot overwritten with the newer one; ovr_cnt +1, saturating at 16'hFFFF.
  - tick with rate_valid=1 and rate_ready=1 in the same cycle: old snapshot accepted, new one loaded, rate_valid stays 1, no overrun.
- cnt_clr in MEASURE: last_cnt <= 0, timer <= 0, no output for that window.
  - If cnt_clr and tick coincide, cnt_clr wins: window discarded, rate_seq unchanged.
  - cnt_clr in IDLE: ignored.
- Reset asserted mid-window or mid-handshake: all state immediately returns to reset values; pending snapshot lost.

Optional Feature:
Macro `RATE_PEAK_HOLD_EN`.
- Defined: on every tick that produces output, rate_peak <= max(rate_peak, delta). Unsigned compare. rate_peak is cleared on reset and on run rising.
- Not defined: rate_peak tied to 0, and no comparator or peak register is synthesized. The port stays present so the interface does not change.

Test Plan:
- WIN_CYCLES=10, cnt_in +1 every cycle, run rises with cnt_in=100, rate_ready=1 -> rate_valid rises 11 cycles after run sampled high. rate_data=10, rate_seq=1; next snapshot 10 cycles later, rate_seq=2.
- Wrap: cnt_in=48'hFFFF_FFFF_FFFA at run entry, +1/cycle, WIN_CYCLES=10 -> rate_data=10 with cnt_in=48'h4 at tick.
- rate_ready=0 across 3 ticks, cnt_in +2/cycle -> rate_valid held, rate_data=20, rate_seq=3, ovr_cnt=2. Then rate_ready=1 -> one accept, rate_valid falls next cycle.
- Tick coincident with accept -> rate_valid stays 1, rate_seq increments, ovr_cnt unchanged.
- cnt_clr pulse on the tick cycle (upstream counter cleared to 0) -> no snapshot for that window. The next window reports exactly the post-clear count, e.g. 10.
- With `RATE_PEAK_HOLD_EN`, windows with deltas 5, 12, 7 -> rate_peak 5, 12, 12. Async rst mid-window -> all outputs 0 immediately. Without the macro, rate_peak stays 0 throughout.
